// File: rtl/bcd2bin_seq_if.sv
// Handshake bundle for the BCD-to-binary converter: digit word in, signed value or error out.
interface bcd2bin_seq_if #(
   parameter int DIGITS = 4
);
   localparam int W = $clog2(10**DIGITS - 1);

   logic                  in_valid;
   logic                  in_ready;
   logic [4*DIGITS-1:0]   in_bcd;
   logic                  out_valid;
   logic                  out_ready;
   logic [W:0]            out_value;
   logic                  out_err;

   modport master (
      output in_valid, in_bcd, out_ready,
      input  in_ready, out_valid, out_value, out_err
   );

   modport slave (
      input  in_valid, in_bcd, out_ready,
      output in_ready, out_valid, out_value, out_err
   );
endinterface

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one nibble per clock, MSD first, with
// leading Empty skip, one optional leading Minus and a sticky format error.
//
// state | meaning
// IDLE  | ready for a new word
// CONV  | consuming one nibble per clock, down-counter tracks nibbles left
// DONE  | result held on the output until the consumer takes it
module bcd2bin_seq #(
   parameter int DIGITS = 4
) (
   input  logic          clk,
   input  logic          reset,
   bcd2bin_seq_if.slave  bus
);
   localparam int W  = $clog2(10**DIGITS - 1);
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t               state, state_nx;
   logic [4*DIGITS-1:0]  sr;
   logic [CW-1:0]        cnt;
   logic [W-1:0]         acc, acc_nx;
   logic                 neg, neg_nx;
   logic                 leading, lead_nx;
   logic                 err, err_nx, err_fin;
   logic [W:0]           mag, val_fin;
   logic [W:0]           out_value_q;
   logic                 out_err_q;
   logic [3:0]           nib;
   logic                 load, step, finish;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step     = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               load     = 1'b1;
               state_nx = CONV;
            end
         end
         CONV: begin
            step = 1'b1;
            if (cnt == '0) begin
               finish   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      nib     = sr[4*DIGITS-1 -: 4];
      acc_nx  = acc;
      neg_nx  = neg;
      lead_nx = leading;
      err_nx  = err;
      if (nib <= 4'd9) begin
         acc_nx  = (acc << 3) + (acc << 1) + W'(nib);
         lead_nx = 1'b0;
      end else if ((nib == 4'hF || nib == 4'hA) && leading && !neg) begin
         neg_nx = (nib == 4'hA);
      end else begin
         err_nx = 1'b1;
      end
      // a Minus with no digit behind it is malformed
      err_fin = err_nx | (neg_nx & lead_nx);
      mag     = {1'b0, acc_nx};
      val_fin = err_fin ? '0 : (neg_nx ? -mag : mag);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr          <= '0;
         cnt         <= '0;
         acc         <= '0;
         neg         <= 1'b0;
         leading     <= 1'b1;
         err         <= 1'b0;
         out_value_q <= '0;
         out_err_q   <= 1'b0;
      end else if (load) begin
         sr      <= bus.in_bcd;
         cnt     <= CW'(DIGITS - 1);
         acc     <= '0;
         neg     <= 1'b0;
         leading <= 1'b1;
         err     <= 1'b0;
      end else if (step) begin
         sr      <= sr << 4;
         cnt     <= cnt - CW'(1);
         acc     <= acc_nx;
         neg     <= neg_nx;
         leading <= lead_nx;
         err     <= err_nx;
         if (finish) begin
            out_value_q <= val_fin;
            out_err_q   <= err_fin;
         end
      end
   end

   assign bus.in_ready  = (state == IDLE) && !reset;
   assign bus.out_valid = (state == DONE);
   assign bus.out_value = out_value_q;
   assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq with DIGITS=4: conversions, malformed words,
// backpressure, back-to-back transfers and reset abort.
module tb_bcd2bin_seq;
   localparam int DIGITS = 4;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   bcd2bin_seq_if #(.DIGITS(DIGITS)) bus ();

   bcd2bin_seq #(.DIGITS(DIGITS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic convert(input string tag, input logic [15:0] bcd,
                          input logic [14:0] exp_val, input logic exp_err);
      int n;
      n = 0;
      while (!bus.in_ready && n < 10) begin
         step();
         n++;
      end
      chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_bcd   = bcd;
      step();
      bus.in_valid = 1'b0;
      bus.in_bcd   = 16'hBEEF;
      n = 0;
      while (!bus.out_valid && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(DIGITS));
      chk({tag, "_val"}, 32'(bus.out_value), 32'(exp_val));
      chk({tag, "_err"}, 32'(bus.out_err), 32'(exp_err));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      int         n;
      int         seen;
      int         n_acc;
      int         n_res;
      logic       acc_now;
      logic [14:0] res [4];

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_bcd    = '0;
      bus.out_ready = 1'b0;
      step();
      step();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_value", 32'(bus.out_value), 32'd0);
      chk("rst_out_err", 32'(bus.out_err), 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

      convert("v1234", 16'h1234, 15'h04D2, 1'b0);
      convert("vneg42", 16'hFA42, 15'h7FD6, 1'b0);
      convert("v9999", 16'h9999, 15'd9999, 1'b0);
      convert("vempty", 16'hFFFF, 15'd0, 1'b0);
      convert("vneg0", 16'hFFA0, 15'd0, 1'b0);
      convert("bad_nib", 16'h12C4, 15'd0, 1'b1);
      convert("bad_emp", 16'h1F23, 15'd0, 1'b1);
      convert("bad_lone", 16'hFFFA, 15'd0, 1'b1);
      convert("bad_minus", 16'h1A23, 15'd0, 1'b1);
      convert("bad_empneg", 16'hAF12, 15'd0, 1'b1);

      // backpressure, with a new word waiting that must not be taken while DONE
      bus.in_valid = 1'b1;
      bus.in_bcd   = 16'h1234;
      step();
      bus.in_bcd   = 16'h0042;
      n = 0;
      while (!bus.out_valid && n < 20) begin
         step();
         n++;
      end
      chk("bp_lat", 32'(n), 32'(DIGITS));
      for (int i = 0; i < 6; i++) begin
         chk("bp_val", 32'(bus.out_value), 32'h04D2);
         chk("bp_ready", 32'(bus.in_ready), 32'd0);
         step();
      end
      chk("bp_valid_held", 32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("bp_drop", 32'(bus.out_valid), 32'd0);
      chk("bp_idle", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 20) begin
         step();
         n++;
      end
      chk("held_lat", 32'(n), 32'(DIGITS));
      chk("held_val", 32'(bus.out_value), 32'h002A);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;

      // back-to-back with in_valid and out_ready held high
      n_acc         = 0;
      n_res         = 0;
      bus.in_valid  = 1'b1;
      bus.in_bcd    = 16'h0007;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         acc_now = bus.in_valid && bus.in_ready;
         if (bus.out_valid && n_res < 4) begin
            res[n_res] = bus.out_value;
            n_res++;
         end
         step();
         if (acc_now) begin
            n_acc++;
            if (n_acc == 1) bus.in_bcd   = 16'hA100;
            else            bus.in_valid = 1'b0;
         end
      end
      bus.out_ready = 1'b0;
      chk("b2b_accepts", 32'(n_acc), 32'd2);
      chk("b2b_results", 32'(n_res), 32'd2);
      if (n_res >= 2) begin
         chk("b2b_first", 32'(res[0]), 32'h0007);
         chk("b2b_second", 32'(res[1]), 32'h7F9C);
      end

      // reset during the second CONV cycle aborts the word
      bus.in_valid = 1'b1;
      bus.in_bcd   = 16'h5555;
      step();
      bus.in_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      seen  = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.out_valid) seen++;
         step();
      end
      chk("rst_abort", 32'(seen), 32'd0);
      chk("rst_clr_val", 32'(bus.out_value), 32'd0);
      convert("after_rst", 16'h0010, 15'd10, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
